// File: rtl/key_event_decoder.sv
// Gesture decoder: turns debounced key edges into single-cycle short/double/long
// press pulses plus a hold level, all registered.
module key_event_decoder #(
  parameter int CNT_W    = 17,
  parameter int LONG_CNT = 128000,
  parameter int DBL_GAP  = 32000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_flag,
  input  logic key_stable,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic key_hold
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             hold_q, hold_d;

  logic press_ev;
  logic release_ev;
  logic long_hit;
  logic gap_hit;

  assign press_ev   = key_flag & ~key_stable;
  assign release_ev = key_flag &  key_stable;
  assign long_hit   = (cnt_q == LONG_LAST);
  assign gap_hit    = (cnt_q == GAP_LAST);

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;

    // Where a key event and a terminal count coincide, the event takes priority.
    unique case (state_q)
      IDLE: begin
        if (press_ev) state_d = PRESS1;
      end
      PRESS1: begin
        if (release_ev) begin
          state_d = WAIT2;
        end else if (long_hit) begin
          state_d = LONG_HOLD;
          long_d  = 1'b1;
        end
      end
      WAIT2: begin
        if (press_ev) begin
          state_d = PRESS2;
        end else if (gap_hit) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESS2: begin
        if (release_ev) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end else if (long_hit) begin
          state_d = LONG_HOLD;
          long_d  = 1'b1;
        end
      end
      LONG_HOLD: begin
        if (release_ev) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    hold_d = (state_d == LONG_HOLD);

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == PRESS1 || state_q == WAIT2 || state_q == PRESS2) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      hold_q   <= hold_d;
    end
  end

  assign short_press  = short_q;
  assign double_press = double_q;
  assign long_press   = long_q;
  assign key_hold     = hold_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: each gesture is replayed edge by edge and
// the four outputs are compared every cycle against hand-derived pulse cycles.
module tb_key_event_decoder;

  localparam int CNT_W    = 17;
  localparam int LONG_CNT = 20;
  localparam int DBL_GAP  = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic key_flag;
  logic key_stable;
  logic short_press;
  logic double_press;
  logic long_press;
  logic key_hold;

  int n_asserts = 0;
  int n_fails   = 0;

  key_event_decoder #(
    .CNT_W   (CNT_W),
    .LONG_CNT(LONG_CNT),
    .DBL_GAP (DBL_GAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_flag    (key_flag),
    .key_stable  (key_stable),
    .short_press (short_press),
    .double_press(double_press),
    .long_press  (long_press),
    .key_hold    (key_hold)
  );

  always #5 clk = ~clk;

  // Drive one edge worth of inputs, then sample just after that edge.
  task automatic step(input logic rn, input logic f, input logic s);
    rst_n      = rn;
    key_flag   = f;
    key_stable = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int cyc, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {short_press, double_press, long_press, key_hold};
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s cycle %0d: observed {short,dbl,long,hold}=%b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // Edge 0 is a reset edge; events are given as edge numbers (0 = unused).
  // Expected pulses are given as the cycle number N+1 following edge N.
  task automatic run_case(input string tag,
                          input int p1, input int r1, input int p2, input int r2,
                          input int rst_e,
                          input int s1, input int s2, input int d, input int l,
                          input int h_from, input int h_to, input int ncyc);
    int fails_before;
    fails_before = n_fails;
    step(1'b0, 1'b0, 1'b1);
    for (int e = 1; e <= ncyc; e++) begin
      logic f, s, rn;
      int c;
      logic [3:0] exp;
      rn = (e != rst_e);
      f  = 1'b0;
      s  = 1'b1;
      if (e == p1 || e == p2) begin f = 1'b1; s = 1'b0; end
      if (e == r1 || e == r2) begin f = 1'b1; s = 1'b1; end
      step(rn, f, s);
      c = e + 1;
      exp = {(c == s1 || c == s2), (c == d), (c == l), (c >= h_from && c <= h_to)};
      check_out(tag, c, exp);
    end
    $display("case %-14s cycles=%0d new_failures=%0d", tag, ncyc, n_fails - fails_before);
  endtask

  initial begin
    rst_n      = 1'b0;
    key_flag   = 1'b0;
    key_stable = 1'b1;

    // Reset with random key activity: outputs held low, counter cleared.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'($urandom), 1'($urandom));
      check_out("reset_hold", i, 4'b0000);
    end
    n_asserts++;
    assert (dut.cnt_q === '0) else begin
      n_fails++;
      $error("FAIL reset_cnt: observed %0d expected 0", dut.cnt_q);
    end
    n_asserts++;
    assert (3'(dut.state_q) === 3'd0) else begin
      n_fails++;
      $error("FAIL reset_state: observed %0d expected 0 (IDLE)", 3'(dut.state_q));
    end
    step(1'b1, 1'b0, 1'b1);
    check_out("reset_release", 0, 4'b0000);
    $display("case reset          cycles=4 failures_so_far=%0d", n_fails);

    //       tag              p1  r1  p2  r2 rst  s1  s2   d   l  hf  ht  n
    run_case("short",         10, 15,  0,  0,  0, 24,  0,  0,  0,  0,  0, 40);
    run_case("double",        10, 13, 18, 21,  0,  0,  0, 22,  0,  0,  0, 40);
    run_case("long",          10, 40,  0,  0,  0,  0,  0,  0, 31, 31, 40, 50);
    run_case("rel_before_lng",10, 29,  0,  0,  0, 38,  0,  0,  0,  0,  0, 50);
    run_case("rel_at_lng",    10, 30,  0,  0,  0, 39,  0,  0,  0,  0,  0, 50);
    run_case("press_at_gap",  10, 13, 21, 24,  0,  0,  0, 25,  0,  0,  0, 45);
    run_case("abort_rst",     10,  0, 16, 20, 15, 29,  0,  0,  0,  0,  0, 45);
    run_case("redundant",     10, 40, 15,  0,  0,  0,  0,  0, 31, 31, 40, 50);
    run_case("after_reset",    1,  3,  0,  0,  0, 12,  0,  0,  0,  0,  0, 25);
    run_case("back_to_back",  10, 15, 24, 26,  0, 24, 35,  0,  0,  0,  0, 45);
    run_case("press2_long",   10, 13, 16, 45,  0,  0,  0,  0, 37, 37, 45, 55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
